// File: rtl/i2c_slave_regfile.sv
`timescale 1ns/1ps
// i2c_slave_regfile: I2C target backed by a 2**REG_AW byte register file with an
// auto-incrementing pointer. Ports: i2c_clk/preset_n (async low), scl_i/sda_i bus inputs,
// sda_pull open-drain SDA drive, busy, wr_valid/wr_addr/wr_data write strobe,
// host_raddr/host_rdata combinational local read port.
// Option: define I2C_SLV_GLITCH_FILTER_EN to add a FILT_LEN-sample glitch filter on SCL/SDA.
module i2c_slave_regfile #(
  parameter logic [6:0] SLV_ADDR = 7'h50,
  parameter int         REG_AW   = 4,
  parameter int         FILT_LEN = 3
) (
  input  logic              i2c_clk,
  input  logic              preset_n,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_pull,
  output logic              busy,
  output logic              wr_valid,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic [REG_AW-1:0] host_raddr,
  output logic [7:0]        host_rdata
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
    WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  localparam int DEPTH = 2 ** REG_AW;

  logic [1:0] scl_sy, sda_sy;
  logic       scl_f, sda_f, scl_q, sda_q;

  always_ff @(posedge i2c_clk or negedge preset_n) begin
    if (!preset_n) begin
      scl_sy <= 2'b11;
      sda_sy <= 2'b11;
    end else begin
      scl_sy <= {scl_sy[0], scl_i};
      sda_sy <= {sda_sy[0], sda_i};
    end
  end

`ifdef I2C_SLV_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILT_LEN + 1);
  logic [FW-1:0] scl_fc, sda_fc;

  // A line only follows the synced input after FILT_LEN differing samples in a row.
  always_ff @(posedge i2c_clk or negedge preset_n) begin
    if (!preset_n) begin
      scl_f  <= 1'b1;
      sda_f  <= 1'b1;
      scl_fc <= '0;
      sda_fc <= '0;
    end else begin
      if (scl_sy[1] == scl_f) begin
        scl_fc <= '0;
      end else if (scl_fc == FW'(FILT_LEN - 1)) begin
        scl_f  <= scl_sy[1];
        scl_fc <= '0;
      end else begin
        scl_fc <= scl_fc + FW'(1);
      end
      if (sda_sy[1] == sda_f) begin
        sda_fc <= '0;
      end else if (sda_fc == FW'(FILT_LEN - 1)) begin
        sda_f  <= sda_sy[1];
        sda_fc <= '0;
      end else begin
        sda_fc <= sda_fc + FW'(1);
      end
    end
  end
`else
  logic unused_filt;
  assign unused_filt = (FILT_LEN > 0);
  assign scl_f = scl_sy[1];
  assign sda_f = sda_sy[1];
`endif

  always_ff @(posedge i2c_clk or negedge preset_n) begin
    if (!preset_n) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start, stop;
  assign scl_rise = scl_f & ~scl_q;
  assign scl_fall = ~scl_f & scl_q;
  assign start    = scl_f & scl_q & sda_q & ~sda_f;
  assign stop     = scl_f & scl_q & ~sda_q & sda_f;

  state_t            state, state_n;
  logic [2:0]        cnt, cnt_n;
  logic [7:0]        shreg, shreg_n;
  logic              half, half_n;
  logic              rw, rw_n;
  logic [REG_AW-1:0] ptr, ptr_n;
  logic              pull_n, busy_n, wv_n, mem_we;
  logic [REG_AW-1:0] wa_n;
  logic [7:0]        wd_n, byte_in, rd_byte;
  logic [7:0]        mem [DEPTH];

  assign byte_in    = {shreg[6:0], sda_f};
  assign rd_byte    = mem[ptr];
  assign host_rdata = mem[host_raddr];

  // half marks the second phase of a 9th clock (ACK being driven / byte finished).
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shreg_n = shreg;
    half_n  = half;
    rw_n    = rw;
    ptr_n   = ptr;
    pull_n  = sda_pull;
    busy_n  = busy;
    wv_n    = 1'b0;
    wa_n    = wr_addr;
    wd_n    = wr_data;
    mem_we  = 1'b0;
    if (stop) begin
      state_n = IDLE;
      busy_n  = 1'b0;
      pull_n  = 1'b0;
      half_n  = 1'b0;
    end else if (start) begin
      state_n = ADDR;
      cnt_n   = 3'd7;
      busy_n  = 1'b0;
      pull_n  = 1'b0;
      half_n  = 1'b0;
    end else begin
      unique case (state)
        ADDR: if (scl_rise) begin
          shreg_n = byte_in;
          cnt_n   = cnt - 3'd1;
          if (cnt == 3'd0) begin
            if (byte_in[7:1] == SLV_ADDR && SLV_ADDR != 7'h00) begin
              state_n = ADDR_ACK;
              busy_n  = 1'b1;
              rw_n    = byte_in[0];
            end else begin
              state_n = IGNORE;
            end
          end
        end
        PTR: if (scl_rise) begin
          shreg_n = byte_in;
          cnt_n   = cnt - 3'd1;
          if (cnt == 3'd0) begin
            ptr_n   = byte_in[REG_AW-1:0];
            state_n = PTR_ACK;
          end
        end
        WR_DATA: if (scl_rise) begin
          shreg_n = byte_in;
          cnt_n   = cnt - 3'd1;
          if (cnt == 3'd0) begin
            mem_we  = 1'b1;
            wv_n    = 1'b1;
            wa_n    = ptr;
            wd_n    = byte_in;
            ptr_n   = ptr + REG_AW'(1);
            state_n = WR_ACK;
          end
        end
        ADDR_ACK, PTR_ACK, WR_ACK: if (scl_fall) begin
          if (!half) begin
            half_n = 1'b1;
            pull_n = 1'b1;
          end else begin
            half_n = 1'b0;
            pull_n = 1'b0;
            cnt_n  = 3'd7;
            if (state == ADDR_ACK && rw) begin
              shreg_n = {rd_byte[6:0], 1'b1};
              pull_n  = ~rd_byte[7];
              ptr_n   = ptr + REG_AW'(1);
              state_n = RD_DATA;
            end else if (state == ADDR_ACK) begin
              state_n = PTR;
            end else begin
              state_n = WR_DATA;
            end
          end
        end
        RD_DATA: begin
          if (scl_rise) begin
            cnt_n = cnt - 3'd1;
            if (cnt == 3'd0) half_n = 1'b1;
          end
          if (scl_fall) begin
            if (half) begin
              half_n  = 1'b0;
              pull_n  = 1'b0;
              state_n = RD_ACK;
            end else begin
              pull_n  = ~shreg[7];
              shreg_n = {shreg[6:0], 1'b1};
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_f) begin
              state_n = IGNORE;
              busy_n  = 1'b0;
            end else begin
              half_n = 1'b1;
            end
          end
          if (scl_fall && half) begin
            half_n  = 1'b0;
            cnt_n   = 3'd7;
            shreg_n = {rd_byte[6:0], 1'b1};
            pull_n  = ~rd_byte[7];
            ptr_n   = ptr + REG_AW'(1);
            state_n = RD_DATA;
          end
        end
        IDLE, IGNORE: ;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge i2c_clk or negedge preset_n) begin
    if (!preset_n) begin
      state    <= IDLE;
      cnt      <= 3'd7;
      shreg    <= '0;
      half     <= 1'b0;
      rw       <= 1'b0;
      ptr      <= '0;
      sda_pull <= 1'b0;
      busy     <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      shreg    <= shreg_n;
      half     <= half_n;
      rw       <= rw_n;
      ptr      <= ptr_n;
      sda_pull <= pull_n;
      busy     <= busy_n;
      wr_valid <= wv_n;
      wr_addr  <= wa_n;
      wr_data  <= wd_n;
    end
  end

  always_ff @(posedge i2c_clk or negedge preset_n) begin
    if (!preset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[ptr] <= byte_in;
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
`timescale 1ns/1ps
// tb_i2c_slave_regfile: bit-level I2C master, transaction-level memory model
// and queue scoreboard for i2c_slave_regfile (SLV_ADDR=7'h50, REG_AW=4).
module tb_i2c_slave_regfile;
  localparam int Q = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_w;
  logic       sda_pull, busy, wr_valid;
  logic [3:0] wr_addr;
  logic [3:0] host_raddr = 4'd0;
  logic [7:0] wr_data, host_rdata;

  assign sda_w = sda_m & ~sda_pull;

  always #5 clk = ~clk;

  i2c_slave_regfile #(.SLV_ADDR(7'h50), .REG_AW(4), .FILT_LEN(3)) dut (
    .i2c_clk(clk), .preset_n(rst_n), .scl_i(scl), .sda_i(sda_w),
    .sda_pull(sda_pull), .busy(busy), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .host_raddr(host_raddr), .host_rdata(host_rdata)
  );

  int total = 0;
  int bad = 0;
  int pull_cyc = 0;

  logic        exp_ack[$], obs_ack[$];
  logic [7:0]  exp_rd[$], obs_rd[$];
  logic [11:0] exp_wr[$];

  logic [7:0] m_mem[16];
  int         m_ptr = 0;
  logic [7:0] dbuf[8];

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (sda_pull) pull_cyc++;
    if (wr_valid) begin
      if (exp_wr.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wr_unexpected act=%0h_%0h exp=none", wr_addr, wr_data);
      end else begin
        chk("wr", {wr_addr, wr_data}, exp_wr.pop_front());
      end
    end
    if (obs_ack.size() > 0) begin
      if (exp_ack.size() == 0) begin
        total++;
        bad++;
        $display("FAIL ack_unexpected act=%0b exp=none", obs_ack.pop_front());
      end else begin
        chk("ack", obs_ack.pop_front(), exp_ack.pop_front());
      end
    end
    if (obs_rd.size() > 0) begin
      if (exp_rd.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_unexpected act=%0h exp=none", obs_rd.pop_front());
      end else begin
        chk("rd", obs_rd.pop_front(), exp_rd.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic wt(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bitc(input logic b, output logic r);
    wt(Q); sda_m = b;
    wt(Q); scl = 1'b1;
    wt(Q); r = sda_w;
    wt(Q); scl = 1'b0;
  endtask

  task automatic i2c_start();
    wt(Q); sda_m = 1'b0;
    wt(2 * Q); scl = 1'b0;
  endtask

  task automatic i2c_rstart();
    wt(Q); sda_m = 1'b1;
    wt(Q); scl = 1'b1;
    wt(Q); sda_m = 1'b0;
    wt(Q); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wt(Q); sda_m = 1'b0;
    wt(Q); scl = 1'b1;
    wt(Q); sda_m = 1'b1;
    wt(2 * Q);
  endtask

  task automatic wbyte(input logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) bitc(b[i], r);
    bitc(1'b1, r);
    obs_ack.push_back(~r);
  endtask

  task automatic rbyte(input logic nack);
    logic r;
    logic [7:0] d;
    for (int i = 7; i >= 0; i--) begin
      bitc(1'b1, r);
      d[i] = r;
    end
    bitc(nack, r);
    obs_rd.push_back(d);
  endtask

  task automatic do_write(input logic [7:0] ab, input logic [7:0] p,
                          input int n);
    logic ok;
    int   pc;
    ok = (ab[7:1] == 7'h50) && !ab[0];
    pc = pull_cyc;
    i2c_start();
    exp_ack.push_back(ok);
    wbyte(ab);
    if (ok) m_ptr = p % 16;
    exp_ack.push_back(ok);
    wbyte(p);
    for (int i = 0; i < n; i++) begin
      exp_ack.push_back(ok);
      if (ok) begin
        exp_wr.push_back({4'(m_ptr), dbuf[i]});
        m_mem[m_ptr] = dbuf[i];
        m_ptr = (m_ptr + 1) % 16;
      end
      wbyte(dbuf[i]);
    end
    i2c_stop();
    chk("busy_after_stop", busy, 0);
    chk("pull_after_stop", sda_pull, 0);
    if (!ok) chk("pull_cycles_nomatch", pull_cyc - pc, 0);
  endtask

  task automatic do_read(input logic [7:0] p, input int n);
    i2c_start();
    exp_ack.push_back(1'b1);
    wbyte(8'hA0);
    m_ptr = p % 16;
    exp_ack.push_back(1'b1);
    wbyte(p);
    i2c_rstart();
    exp_ack.push_back(1'b1);
    wbyte(8'hA1);
    for (int i = 0; i < n; i++) begin
      exp_rd.push_back(m_mem[m_ptr]);
      m_ptr = (m_ptr + 1) % 16;
      rbyte(i == n - 1);
    end
    chk("busy_after_nack", busy, 0);
    chk("pull_after_nack", sda_pull, 0);
    i2c_stop();
  endtask

  task automatic cmp_mem(input string nm);
    for (int i = 0; i < 16; i++) begin
      host_raddr = 4'(i);
      #1;
      chk(nm, host_rdata, m_mem[i]);
    end
  endtask

  initial begin
    logic       r;
    logic [7:0] ab;
    int         kind;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;

    wt(3);
    chk("rst_pull", sda_pull, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    cmp_mem("rst_mem");
    rst_n = 1'b1;
    wt(5);

    dbuf[0] = 8'h5A; dbuf[1] = 8'hC3;
    do_write(8'hA0, 8'h03, 2);
    host_raddr = 4'd3; #1; chk("t1_mem3", host_rdata, 8'h5A);
    host_raddr = 4'd4; #1; chk("t1_mem4", host_rdata, 8'hC3);

    do_read(8'h03, 2);

    dbuf[0] = 8'h77; dbuf[1] = 8'h88;
    do_write(8'hA2, 8'h03, 2);

    dbuf[0] = 8'h11; dbuf[1] = 8'h22;
    do_write(8'hA0, 8'h0F, 2);
    dbuf[0] = 8'h99;
    do_write(8'hA0, 8'hF3, 1);
    cmp_mem("t4_mem");

    i2c_start();
    exp_ack.push_back(1'b1); wbyte(8'hA0);
    exp_ack.push_back(1'b1); wbyte(8'h05);
    m_ptr = 5;
    for (int i = 0; i < 4; i++) bitc(1'b0, r);
    i2c_stop();
    chk("t5_busy", busy, 0);

    for (int t = 0; t < 20; t++) begin
      kind = $urandom_range(0, 3);
      for (int i = 0; i < 8; i++) dbuf[i] = 8'($urandom);
      if (kind == 2) begin
        do_read(8'($urandom), $urandom_range(1, 4));
      end else begin
        ab = 8'hA0;
        if (kind == 3) begin
          ab = {7'($urandom_range(0, 127)), 1'b0};
          if (ab[7:1] == 7'h50) ab = 8'hA4;
        end
        do_write(ab, 8'($urandom), $urandom_range(1, 4));
      end
    end
    cmp_mem("rand_mem");

    i2c_start();
    exp_ack.push_back(1'b1);
    wbyte(8'hA0);
    chk("t6_busy_before", busy, 1);
    wt(Q); sda_m = 1'b1;
    wt(Q); scl = 1'b1;
    wt(Q); sda_m = 1'b0;
    wt(1); sda_m = 1'b1;
    wt(10);
`ifdef I2C_SLV_GLITCH_FILTER_EN
    chk("t6_busy_glitch", busy, 1);
`else
    chk("t6_busy_glitch", busy, 0);
`endif
    scl = 1'b0;
    i2c_stop();

    i2c_start();
    ab = 8'hA0;
    for (int i = 7; i >= 0; i--) bitc(ab[i], r);
    wt(8);
    chk("t5_pull_ack", sda_pull, 1);
    chk("t5_busy_ack", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_pull_rst", sda_pull, 0);
    chk("t5_busy_rst", busy, 0);
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_ptr = 0;
    cmp_mem("post_rst_mem");
    sda_m = 1'b1;
    scl = 1'b1;
    wt(3);
    rst_n = 1'b1;
    wt(5);

    dbuf[0] = 8'h3C;
    do_write(8'hA0, 8'h07, 1);
    do_read(8'h06, 3);

    wt(20);
    chk("left_exp_wr", exp_wr.size(), 0);
    chk("left_exp_ack", exp_ack.size(), 0);
    chk("left_exp_rd", exp_rd.size(), 0);
    chk("left_obs_ack", obs_ack.size(), 0);
    chk("left_obs_rd", obs_rd.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
